// File: rtl/ram_slot_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ram_slot_arbiter_pkg
//  Brief    : Shared state encoding, wrap constants and slot timing for the
//             BBC micro main-RAM slot arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package ram_slot_arbiter_pkg;

    localparam logic [14:0] WRAP_16K = 15'h4000;
    localparam logic [14:0] WRAP_8K  = 15'h6000;
    localparam logic [14:0] WRAP_20K = 15'h3000;
    localparam logic [14:0] WRAP_10K = 15'h5800;
    localparam logic [14:0] TTX_BASE = 15'h7C00;

    localparam int unsigned SLOT_LEN = 4;
    localparam int unsigned CNT_W    = $clog2(SLOT_LEN);

    localparam logic [CNT_W-1:0] CAPTURE_IDX = CNT_W'(SLOT_LEN - 1);
    localparam logic [CNT_W-1:0] WE_FIRST    = CNT_W'(1);
    localparam logic [CNT_W-1:0] WE_LAST     = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_SLOT = 2'd1,
        VID_SLOT = 2'd2
    } slot_state_t;

    // Hardware-scroll wrap offset selected by the VIA C5:C4 bits.
    function automatic logic [14:0] wrap_offset(input logic [1:0] screen_size);
        logic [14:0] w_off;
        case (screen_size)
            2'b00:   w_off = WRAP_16K;
            2'b01:   w_off = WRAP_8K;
            2'b10:   w_off = WRAP_20K;
            default: w_off = WRAP_10K;
        endcase
        return w_off;
    endfunction

endpackage : ram_slot_arbiter_pkg
`default_nettype wire

// File: rtl/ram_slot_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ram_slot_arbiter_if
//  Brief    : Timing strobes, CPU bus, CRTC video bus and RAM port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface ram_slot_arbiter_if;

    logic        RAM_en;
    logic        PROC_en;
    logic [15:0] CPU_ADDR;
    logic        CPU_WE;
    logic [7:0]  CPU_DOUT;
    logic [7:0]  CPU_DIN;
    logic [13:0] VID_MA;
    logic [2:0]  VID_RA;
    logic [1:0]  SCREEN_SIZE;
    logic [7:0]  VID_DATA;
    logic        VID_STROBE;
    logic [14:0] RAM_ADDR;
    logic        RAM_WE;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  RAM_RDATA;

    // Arbiter side.
    modport slave (
        input  RAM_en, PROC_en,
        input  CPU_ADDR, CPU_WE, CPU_DOUT,
        output CPU_DIN,
        input  VID_MA, VID_RA, SCREEN_SIZE,
        output VID_DATA, VID_STROBE,
        output RAM_ADDR, RAM_WE, RAM_WDATA,
        input  RAM_RDATA
    );

    // Surrounding system: timing generator, CPU, CRTC and RAM.
    modport master (
        output RAM_en, PROC_en,
        output CPU_ADDR, CPU_WE, CPU_DOUT,
        input  CPU_DIN,
        output VID_MA, VID_RA, SCREEN_SIZE,
        input  VID_DATA, VID_STROBE,
        input  RAM_ADDR, RAM_WE, RAM_WDATA,
        output RAM_RDATA
    );

endinterface : ram_slot_arbiter_if
`default_nettype wire

// File: rtl/ram_slot_arbiter_screen_addr_xlate.sv
`default_nettype none
// ============================================================================
//  Module   : screen_addr_xlate
//  Brief    : CRTC MA/RA to 15-bit RAM address, with teletext window and
//             hardware-scroll wrap.
//  Revision : 1.0  initial release
// ============================================================================
module screen_addr_xlate
    import ram_slot_arbiter_pkg::*;
(
    input  wire logic [13:0] i_vid_ma,
    input  wire logic [2:0]  i_vid_ra,
    input  wire logic [1:0]  i_screen_size,
    output logic      [14:0] o_addr
);

    logic [14:0] w_base;
    logic [14:0] w_wrapped;

    always_comb begin
        w_base    = {i_vid_ma[11:0], i_vid_ra};
        // 15-bit sum discards the carry, giving the mod-32K wrap.
        w_wrapped = w_base + wrap_offset(i_screen_size);
        if (i_vid_ma[13]) begin
            o_addr = TTX_BASE | {5'd0, i_vid_ma[9:0]};
        end else if (i_vid_ma[12]) begin
            o_addr = w_wrapped;
        end else begin
            o_addr = w_base;
        end
    end

endmodule : screen_addr_xlate
`default_nettype wire

// File: rtl/ram_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ram_slot_arbiter
//  Brief    : Time-slices main RAM between the 6502 and video fetch in 4-cycle
//             slots; latches read data for the CPU and the video shifter.
//  Revision : 1.0  initial release
// ============================================================================
module ram_slot_arbiter
    import ram_slot_arbiter_pkg::*;
(
    input  wire logic       PIXELCLK,
    input  wire logic       RESET,
    ram_slot_arbiter_if.slave bus
);

    slot_state_t      r_state;
    slot_state_t      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             w_capture;
    logic             w_cap_cpu;
    logic             w_cap_vid;
    logic             w_ram_we;
    logic [14:0]      w_vid_addr;

    logic [14:0]      r_addr;
    logic [7:0]       r_wdata;
    logic             r_wr;
    logic             r_ram_sel;
    logic [7:0]       r_cpu_din;
    logic [7:0]       r_vid_data;
    logic             r_vid_pend;
    logic             r_vid_strobe;

    screen_addr_xlate u_xlate (
        .i_vid_ma      (bus.VID_MA),
        .i_vid_ra      (bus.VID_RA),
        .i_screen_size (bus.SCREEN_SIZE),
        .o_addr        (w_vid_addr)
    );

    always_ff @(posedge PIXELCLK) begin
        if (RESET) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A RAM_en at any cycle, even mid-slot, starts a fresh slot; capture only
    // happens when the count has reached the final slot cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_ram_we    = 1'b0;
        if (r_state != IDLE) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CAPTURE_IDX) begin
                w_capture   = 1'b1;
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
            if ((r_state == CPU_SLOT) && r_wr && r_ram_sel &&
                ((r_cnt == WE_FIRST) || (r_cnt == WE_LAST))) begin
                w_ram_we = 1'b1;
            end
        end
        if (bus.RAM_en) begin
            w_state_nxt = bus.PROC_en ? CPU_SLOT : VID_SLOT;
            w_cnt_nxt   = '0;
        end
        w_cap_cpu = w_capture && (r_state == CPU_SLOT) && !r_wr && r_ram_sel;
        w_cap_vid = w_capture && (r_state == VID_SLOT);
    end

    always_ff @(posedge PIXELCLK) begin
        if (RESET) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wr         <= 1'b0;
            r_ram_sel    <= 1'b0;
            r_cpu_din    <= '0;
            r_vid_data   <= '0;
            r_vid_pend   <= 1'b0;
            r_vid_strobe <= 1'b0;
        end else begin
            r_vid_pend   <= w_cap_vid;
            r_vid_strobe <= r_vid_pend;
            if (w_cap_cpu) begin
                r_cpu_din <= bus.RAM_RDATA;
            end
            if (w_cap_vid) begin
                r_vid_data <= bus.RAM_RDATA;
            end
            if (bus.RAM_en) begin
                if (bus.PROC_en) begin
                    r_addr    <= bus.CPU_ADDR[14:0];
                    r_wdata   <= bus.CPU_DOUT;
                    r_wr      <= bus.CPU_WE;
                    r_ram_sel <= ~bus.CPU_ADDR[15];
                end else begin
                    r_addr    <= w_vid_addr;
                    r_wr      <= 1'b0;
                    r_ram_sel <= 1'b0;
                end
            end
        end
    end

    assign bus.RAM_ADDR   = r_addr;
    assign bus.RAM_WE     = w_ram_we;
    assign bus.RAM_WDATA  = r_wdata;
    assign bus.CPU_DIN    = r_cpu_din;
    assign bus.VID_DATA   = r_vid_data;
    assign bus.VID_STROBE = r_vid_strobe;

    // The timing generator only raises PROC_en on a slot start.
    a_proc_in_ram_en : assert property (
        @(posedge PIXELCLK) disable iff (RESET) bus.PROC_en |-> bus.RAM_en
    );

endmodule : ram_slot_arbiter
`default_nettype wire

// File: tb/tb_ram_slot_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ram_slot_arbiter
//  Brief    : Directed self-checking bench for ram_slot_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ram_slot_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ram_slot_arbiter_if u_if ();

    ram_slot_arbiter u_dut (
        .PIXELCLK (clk),
        .RESET    (rst),
        .bus      (u_if.slave)
    );

    bit [7:0] mem [0:32767];
    bit       loaded   = 1'b0;
    int       wr_count = 0;

    assign u_if.RAM_RDATA = mem[u_if.RAM_ADDR];

    always @(posedge clk) begin
        if (!loaded) begin
            mem[15'h0081] <= 8'h5A;
            mem[15'h0100] <= 8'h77;
            mem[15'h4002] <= 8'h3C;
            mem[15'h3002] <= 8'hC3;
            loaded        <= 1'b1;
        end else if (u_if.RAM_WE === 1'b1) begin
            mem[u_if.RAM_ADDR] <= u_if.RAM_WDATA;
            wr_count           <= wr_count + 1;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic decide(input logic proc);
        u_if.RAM_en  = 1'b1;
        u_if.PROC_en = proc;
        tick();
        u_if.RAM_en  = 1'b0;
        u_if.PROC_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        u_if.RAM_en = 1'b0; u_if.PROC_en = 1'b0;
        u_if.CPU_ADDR = 16'h0000; u_if.CPU_WE = 1'b0; u_if.CPU_DOUT = 8'h00;
        u_if.VID_MA = 14'h0000; u_if.VID_RA = 3'd0; u_if.SCREEN_SIZE = 2'b00;
        idle(3);
        u_if.CPU_ADDR = 16'h1111; u_if.CPU_WE = 1'b1; u_if.CPU_DOUT = 8'hEE;
        decide(1'b1);
        u_if.CPU_WE = 1'b0;
        tick();
        checks++; if (u_if.RAM_ADDR !== 15'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", u_if.RAM_ADDR); end
        checks++; if (u_if.RAM_WE !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", u_if.RAM_WE); end
        checks++; if (u_if.RAM_WDATA !== 8'h00) begin errors++; $display("FAIL reset_wdata got %h want 00", u_if.RAM_WDATA); end
        checks++; if (u_if.CPU_DIN !== 8'h00) begin errors++; $display("FAIL reset_cpu_din got %h want 00", u_if.CPU_DIN); end
        checks++; if (u_if.VID_DATA !== 8'h00) begin errors++; $display("FAIL reset_vid_data got %h want 00", u_if.VID_DATA); end
        checks++; if (u_if.VID_STROBE !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", u_if.VID_STROBE); end
        rst = 1'b0;
        idle(2);
        checks++; if (u_if.RAM_ADDR !== 15'h0000) begin errors++; $display("FAIL idle_addr got %h want 0000", u_if.RAM_ADDR); end
    endtask

    task automatic test_free_run();
        int nstrobe = 0;
        int first   = -1;
        int last    = -1;
        int we_hi   = 0;
        u_if.CPU_ADDR = 16'h0100; u_if.CPU_WE = 1'b0;
        u_if.VID_MA = 14'h0010; u_if.VID_RA = 3'd1; u_if.SCREEN_SIZE = 2'b00;
        for (int i = 0; i < 32; i++) begin
            u_if.RAM_en  = ((i % 4) == 0);
            u_if.PROC_en = ((i % 8) == 4);
            tick();
            if (u_if.RAM_WE !== 1'b0) we_hi++;
            if (u_if.VID_STROBE === 1'b1) begin
                nstrobe++;
                if (first < 0) first = i;
                last = i;
            end
        end
        u_if.RAM_en = 1'b0; u_if.PROC_en = 1'b0;
        checks++; if (we_hi !== 0) begin errors++; $display("FAIL run_we_cycles got %0d want 0", we_hi); end
        checks++; if (nstrobe !== 4) begin errors++; $display("FAIL run_strobe_count got %0d want 4", nstrobe); end
        checks++; if (first !== 5) begin errors++; $display("FAIL run_first_strobe got %0d want 5", first); end
        checks++; if (last !== 29) begin errors++; $display("FAIL run_last_strobe got %0d want 29", last); end
        checks++; if (u_if.VID_DATA !== 8'h5A) begin errors++; $display("FAIL run_vid_data got %h want 5a", u_if.VID_DATA); end
        checks++; if (u_if.CPU_DIN !== 8'h77) begin errors++; $display("FAIL run_cpu_din got %h want 77", u_if.CPU_DIN); end
        idle(4);
    endtask

    task automatic test_cpu_write();
        u_if.CPU_ADDR = 16'h1234; u_if.CPU_DOUT = 8'hA5; u_if.CPU_WE = 1'b1;
        decide(1'b1);
        checks++; if (u_if.RAM_ADDR !== 15'h1234) begin errors++; $display("FAIL wr_addr got %h want 1234", u_if.RAM_ADDR); end
        checks++; if (u_if.RAM_WDATA !== 8'hA5) begin errors++; $display("FAIL wr_wdata got %h want a5", u_if.RAM_WDATA); end
        checks++; if (u_if.RAM_WE !== 1'b0) begin errors++; $display("FAIL wr_we_c0 got %b want 0", u_if.RAM_WE); end
        u_if.CPU_ADDR = 16'h0000; u_if.CPU_DOUT = 8'h00; u_if.CPU_WE = 1'b0;
        tick();
        checks++; if (u_if.RAM_WE !== 1'b1) begin errors++; $display("FAIL wr_we_c1 got %b want 1", u_if.RAM_WE); end
        checks++; if ({u_if.RAM_ADDR, u_if.RAM_WDATA} !== {15'h1234, 8'hA5}) begin errors++; $display("FAIL wr_hold got %h/%h want 1234/a5", u_if.RAM_ADDR, u_if.RAM_WDATA); end
        tick();
        checks++; if (u_if.RAM_WE !== 1'b1) begin errors++; $display("FAIL wr_we_c2 got %b want 1", u_if.RAM_WE); end
        tick();
        checks++; if (u_if.RAM_WE !== 1'b0) begin errors++; $display("FAIL wr_we_c3 got %b want 0", u_if.RAM_WE); end
        u_if.CPU_ADDR = 16'h1234;
        decide(1'b1);
        checks++; if (u_if.CPU_DIN !== 8'h77) begin errors++; $display("FAIL wr_no_capture got %h want 77", u_if.CPU_DIN); end
        idle(3);
        decide(1'b0);
        checks++; if (u_if.CPU_DIN !== 8'hA5) begin errors++; $display("FAIL rd_back got %h want a5", u_if.CPU_DIN); end
        idle(4);
    endtask

    task automatic test_nonram();
        int we_hi = 0;
        int snap  = wr_count;
        u_if.CPU_ADDR = 16'hFE40; u_if.CPU_DOUT = 8'h11; u_if.CPU_WE = 1'b1;
        decide(1'b1);
        u_if.CPU_WE = 1'b0;
        if (u_if.RAM_WE !== 1'b0) we_hi++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (u_if.RAM_WE !== 1'b0) we_hi++;
        end
        decide(1'b0);
        checks++; if (we_hi !== 0) begin errors++; $display("FAIL io_we_cycles got %0d want 0", we_hi); end
        checks++; if (wr_count !== snap) begin errors++; $display("FAIL io_ram_writes got %0d want %0d", wr_count, snap); end
        checks++; if (u_if.CPU_DIN !== 8'hA5) begin errors++; $display("FAIL io_cpu_din got %h want a5", u_if.CPU_DIN); end
        idle(4);
    endtask

    task automatic test_video();
        u_if.VID_MA = 14'h1000; u_if.VID_RA = 3'd2; u_if.SCREEN_SIZE = 2'b00;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h4002) begin errors++; $display("FAIL vid_16k got %h want 4002", u_if.RAM_ADDR); end
        idle(3);
        u_if.SCREEN_SIZE = 2'b10;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h3002) begin errors++; $display("FAIL vid_20k got %h want 3002", u_if.RAM_ADDR); end
        checks++; if (u_if.VID_DATA !== 8'h3C) begin errors++; $display("FAIL vid_data got %h want 3c", u_if.VID_DATA); end
        checks++; if (u_if.VID_STROBE !== 1'b0) begin errors++; $display("FAIL vid_strobe_early got %b want 0", u_if.VID_STROBE); end
        tick();
        checks++; if (u_if.VID_STROBE !== 1'b1) begin errors++; $display("FAIL vid_strobe got %b want 1", u_if.VID_STROBE); end
        tick();
        checks++; if (u_if.VID_STROBE !== 1'b0) begin errors++; $display("FAIL vid_strobe_width got %b want 0", u_if.VID_STROBE); end
        tick();
        u_if.VID_MA = 14'h2005;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h7C05) begin errors++; $display("FAIL vid_ttx got %h want 7c05", u_if.RAM_ADDR); end
        checks++; if (u_if.VID_DATA !== 8'hC3) begin errors++; $display("FAIL vid_data2 got %h want c3", u_if.VID_DATA); end
        idle(3);
        u_if.VID_MA = 14'h1FFF; u_if.VID_RA = 3'd7; u_if.SCREEN_SIZE = 2'b11;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h57FF) begin errors++; $display("FAIL vid_10k_wrap got %h want 57ff", u_if.RAM_ADDR); end
        idle(3);
        u_if.VID_MA = 14'h1000; u_if.VID_RA = 3'd0; u_if.SCREEN_SIZE = 2'b01;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h6000) begin errors++; $display("FAIL vid_8k got %h want 6000", u_if.RAM_ADDR); end
        idle(3);
        u_if.VID_MA = 14'h0123; u_if.VID_RA = 3'd5;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h091D) begin errors++; $display("FAIL vid_nowrap got %h want 091d", u_if.RAM_ADDR); end
        idle(4);
    endtask

    task automatic test_reset_midslot();
        int snap;
        u_if.CPU_ADDR = 16'h0200; u_if.CPU_DOUT = 8'h99; u_if.CPU_WE = 1'b1;
        decide(1'b1);
        tick();
        checks++; if (u_if.RAM_WE !== 1'b1) begin errors++; $display("FAIL rst_we_c1 got %b want 1", u_if.RAM_WE); end
        rst = 1'b1;
        tick();
        checks++; if (u_if.RAM_WE !== 1'b0) begin errors++; $display("FAIL rst_we_drop got %b want 0", u_if.RAM_WE); end
        snap = wr_count;
        decide(1'b1);
        tick();
        checks++; if (wr_count !== snap) begin errors++; $display("FAIL rst_ram_writes got %0d want %0d", wr_count, snap); end
        checks++; if (u_if.RAM_ADDR !== 15'h0000) begin errors++; $display("FAIL rst_addr got %h want 0000", u_if.RAM_ADDR); end
        checks++; if (u_if.CPU_DIN !== 8'h00) begin errors++; $display("FAIL rst_cpu_din got %h want 00", u_if.CPU_DIN); end
        rst = 1'b0;
        u_if.CPU_WE = 1'b0;
        tick();
        checks++; if (u_if.RAM_ADDR !== 15'h0000) begin errors++; $display("FAIL post_rst_idle got %h want 0000", u_if.RAM_ADDR); end
        u_if.VID_MA = 14'h1000; u_if.VID_RA = 3'd2; u_if.SCREEN_SIZE = 2'b00;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h4002) begin errors++; $display("FAIL post_rst_align got %h want 4002", u_if.RAM_ADDR); end
        idle(3);
        u_if.CPU_ADDR = 16'h0100;
        decide(1'b1);
        checks++; if (u_if.VID_DATA !== 8'h3C) begin errors++; $display("FAIL post_rst_vid got %h want 3c", u_if.VID_DATA); end
        // RAM_en one cycle into the CPU slot: protocol violation on purpose.
        $display("NOTE protocol violation: RAM_en at slot cycle 0");
        u_if.SCREEN_SIZE = 2'b10;
        decide(1'b0);
        checks++; if (u_if.RAM_ADDR !== 15'h3002) begin errors++; $display("FAIL viol_restart got %h want 3002", u_if.RAM_ADDR); end
        idle(3);
        decide(1'b1);
        checks++; if (u_if.VID_DATA !== 8'hC3) begin errors++; $display("FAIL viol_vid got %h want c3", u_if.VID_DATA); end
        checks++; if (u_if.CPU_DIN !== 8'h00) begin errors++; $display("FAIL viol_no_capture got %h want 00", u_if.CPU_DIN); end
        idle(3);
        decide(1'b0);
        checks++; if (u_if.CPU_DIN !== 8'h77) begin errors++; $display("FAIL viol_cpu_next got %h want 77", u_if.CPU_DIN); end
        idle(4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_free_run();
        test_cpu_write();
        test_nonram();
        test_video();
        test_reset_midslot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_slot_arbiter
`default_nettype wire
